// File: rtl/frame_buffer_scheduler_pkg.sv
// Shared types and defaults for the double-buffered frame scheduler.
package frame_sched_pkg;

    localparam int unsigned VRAM_A_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        S_START     = 2'd0,
        S_WAIT_BUSY = 2'd1,
        S_DRAW      = 2'd2,
        S_READY     = 2'd3
    } sched_state_t;

    // Bits needed to count 0 .. n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_buffer_scheduler_sat_counter.sv
// Up-counter with synchronous clear and optional saturation at all-ones.
module sat_counter
    import frame_sched_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             saturate,
    output logic [WIDTH-1:0] count
);

    logic at_max;

    assign at_max = (count == '1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !(saturate && at_max)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Frame sequencer for a two-bank VRAM: starts the layer controller, gates its
// writes into the draw bank and swaps banks at vsync once drawing is done.
module frame_buffer_scheduler
    import frame_sched_pkg::*;
#(
    parameter int unsigned VRAM_A_WIDTH    = VRAM_A_WIDTH_DEF,
    parameter int unsigned WAIT_TIMEOUT    = 1024,
    parameter int unsigned DROP_CNT_WIDTH  = 8,
    parameter int unsigned FRAME_CNT_WIDTH = 16
) (
    input  logic                       CLK,
    input  logic                       rst,
    input  logic                       pix_stb,
    input  logic                       screenend,
    input  logic                       i_layer_drawing,
    input  logic [VRAM_A_WIDTH-1:0]    i_draw_address,
    input  logic                       i_draw_we,
    input  logic [VRAM_A_WIDTH-1:0]    i_scan_address,
    output logic                       o_frame_start,
    output logic [VRAM_A_WIDTH:0]      o_wr_address,
    output logic                       o_wr_en,
    output logic [VRAM_A_WIDTH:0]      o_rd_address,
    output logic                       o_disp_bank,
    output logic [DROP_CNT_WIDTH-1:0]  o_drop_cnt,
    output logic [FRAME_CNT_WIDTH-1:0] o_frame_cnt,
    output logic                       o_timeout
);

    localparam int unsigned TW = cnt_width(WAIT_TIMEOUT);
    localparam logic [TW-1:0] WAIT_LAST = TW'(WAIT_TIMEOUT - 1);

    sched_state_t state;
    logic         disp_bank;
    logic         draw_bank;
    logic         vsync;
    logic         wait_last;
    logic         wait_clr;
    logic         wait_inc;
    logic         drop_inc;
    logic [TW-1:0] wait_cnt;

    assign vsync     = pix_stb & screenend;
    assign draw_bank = ~disp_bank;
    assign wait_last = (wait_cnt == WAIT_LAST);

    // Counter runs only while waiting for busy and is zero in every other state.
    always_comb begin
        wait_inc = 1'b0;
        wait_clr = 1'b1;
        drop_inc = 1'b0;
        if (state == S_WAIT_BUSY) begin
            wait_inc = 1'b1;
            wait_clr = i_layer_drawing | wait_last;
        end
        if (state != S_READY) begin
            drop_inc = vsync;
        end
    end

    sat_counter #(
        .WIDTH (TW)
    ) u_wait_cnt (
        .clk      (CLK),
        .rst      (rst),
        .clr      (wait_clr),
        .inc      (wait_inc),
        .saturate (1'b1),
        .count    (wait_cnt)
    );

    sat_counter #(
        .WIDTH (DROP_CNT_WIDTH)
    ) u_drop_cnt (
        .clk      (CLK),
        .rst      (rst),
        .clr      (1'b0),
        .inc      (drop_inc),
        .saturate (1'b1),
        .count    (o_drop_cnt)
    );

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state         <= S_START;
            disp_bank     <= 1'b0;
            o_frame_start <= 1'b1;
            o_frame_cnt   <= '0;
            o_timeout     <= 1'b0;
        end else begin
            case (state)
                S_START: begin
                    if (pix_stb) begin
                        state         <= S_WAIT_BUSY;
                        o_frame_start <= 1'b0;
                    end
                end
                S_WAIT_BUSY: begin
                    if (i_layer_drawing) begin
                        state <= S_DRAW;
                    end else if (wait_last) begin
                        state         <= S_START;
                        o_frame_start <= 1'b1;
                        o_timeout     <= 1'b1;
                    end
                end
                S_DRAW: begin
                    if (!i_layer_drawing) begin
                        state <= S_READY;
                    end
                end
                S_READY: begin
                    if (vsync) begin
                        state         <= S_START;
                        disp_bank     <= ~disp_bank;
                        o_frame_cnt   <= o_frame_cnt + FRAME_CNT_WIDTH'(1);
                        o_frame_start <= 1'b1;
                    end
                end
                default: state <= S_START;
            endcase
        end
    end

    assign o_disp_bank  = disp_bank;
    assign o_wr_address = {draw_bank, i_draw_address};
    assign o_rd_address = {disp_bank, i_scan_address};
    assign o_wr_en      = i_draw_we & i_layer_drawing & (state == S_DRAW);

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Directed bench for frame_buffer_scheduler: reset, swap, drops, gating, timeout, saturation.
module tb_frame_buffer_scheduler;

    localparam int unsigned AW = 16;

    logic          CLK = 1'b0;
    logic          rst;
    logic          pix_stb;
    logic          screenend;
    logic          i_layer_drawing;
    logic [AW-1:0] i_draw_address;
    logic          i_draw_we;
    logic [AW-1:0] i_scan_address;
    logic          o_frame_start;
    logic [AW:0]   o_wr_address;
    logic          o_wr_en;
    logic [AW:0]   o_rd_address;
    logic          o_disp_bank;
    logic [7:0]    o_drop_cnt;
    logic [15:0]   o_frame_cnt;
    logic          o_timeout;

    int unsigned total = 0;
    int unsigned bad = 0;

    frame_buffer_scheduler #(
        .VRAM_A_WIDTH    (AW),
        .WAIT_TIMEOUT    (16),
        .DROP_CNT_WIDTH  (8),
        .FRAME_CNT_WIDTH (16)
    ) dut (
        .CLK             (CLK),
        .rst             (rst),
        .pix_stb         (pix_stb),
        .screenend       (screenend),
        .i_layer_drawing (i_layer_drawing),
        .i_draw_address  (i_draw_address),
        .i_draw_we       (i_draw_we),
        .i_scan_address  (i_scan_address),
        .o_frame_start   (o_frame_start),
        .o_wr_address    (o_wr_address),
        .o_wr_en         (o_wr_en),
        .o_rd_address    (o_rd_address),
        .o_disp_bank     (o_disp_bank),
        .o_drop_cnt      (o_drop_cnt),
        .o_frame_cnt     (o_frame_cnt),
        .o_timeout       (o_timeout)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset;
        rst = 1'b0; pix_stb = 1'b0; screenend = 1'b0; i_layer_drawing = 1'b0;
        i_draw_address = '0; i_draw_we = 1'b0; i_scan_address = 16'hABCD;
        @(negedge CLK);
        total++; if (o_frame_start !== 1'b1) begin bad++; $display("FAIL rst_frame_start: got %b want 1", o_frame_start); end
        total++; if (o_disp_bank !== 1'b0) begin bad++; $display("FAIL rst_disp_bank: got %b want 0", o_disp_bank); end
        total++; if (o_drop_cnt !== 8'd0) begin bad++; $display("FAIL rst_drop_cnt: got %0d want 0", o_drop_cnt); end
        total++; if (o_frame_cnt !== 16'd0) begin bad++; $display("FAIL rst_frame_cnt: got %0d want 0", o_frame_cnt); end
        total++; if (o_timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %b want 0", o_timeout); end
        total++; if (o_rd_address !== 17'h0ABCD) begin bad++; $display("FAIL rst_rd_addr: got %h want 0abcd", o_rd_address); end
        rst = 1'b1;
        for (int unsigned c = 0; c < 3; c++) begin
            total++; if (o_frame_start !== 1'b1) begin bad++; $display("FAIL start_hold_c%0d: got %b want 1", c, o_frame_start); end
            if (c == 2) pix_stb = 1'b1;
            tick;
        end
        pix_stb = 1'b0;
        total++; if (o_frame_start !== 1'b0) begin bad++; $display("FAIL start_drop_c3: got %b want 0", o_frame_start); end
        i_draw_we = 1'b1; #1;
        total++; if (o_wr_en !== 1'b0) begin bad++; $display("FAIL wait_wr_en: got %b want 0", o_wr_en); end
        i_draw_we = 1'b0;
        total++; if (o_disp_bank !== 1'b0) begin bad++; $display("FAIL wait_disp_bank: got %b want 0", o_disp_bank); end
        total++; if (o_wr_address[AW] !== 1'b1) begin bad++; $display("FAIL wait_wr_msb: got %b want 1", o_wr_address[AW]); end
    endtask

    task automatic test_swap;
        i_layer_drawing = 1'b1;
        tick;
        i_draw_address = 16'h1234; i_draw_we = 1'b1; #1;
        total++; if (o_wr_en !== 1'b1) begin bad++; $display("FAIL draw_wr_en: got %b want 1", o_wr_en); end
        total++; if (o_wr_address !== 17'h11234) begin bad++; $display("FAIL draw_wr_addr: got %h want 11234", o_wr_address); end
        i_draw_we = 1'b0; #1;
        total++; if (o_wr_en !== 1'b0) begin bad++; $display("FAIL draw_we_low: got %b want 0", o_wr_en); end
        repeat (98) tick;
        total++; if (o_frame_start !== 1'b0) begin bad++; $display("FAIL draw_frame_start: got %b want 0", o_frame_start); end
        i_layer_drawing = 1'b0;
        tick;
        i_draw_we = 1'b1; #1;
        total++; if (o_wr_en !== 1'b0) begin bad++; $display("FAIL ready_wr_en: got %b want 0", o_wr_en); end
        i_layer_drawing = 1'b1; #1;
        total++; if (o_wr_en !== 1'b0) begin bad++; $display("FAIL ready_busy_wr_en: got %b want 0", o_wr_en); end
        i_layer_drawing = 1'b0; i_draw_we = 1'b0;
        repeat (3) tick;
        total++; if (o_disp_bank !== 1'b0) begin bad++; $display("FAIL ready_no_swap: got %b want 0", o_disp_bank); end
        pix_stb = 1'b1; screenend = 1'b1; #1;
        total++; if (o_rd_address !== 17'h0ABCD) begin bad++; $display("FAIL pre_swap_rd: got %h want 0abcd", o_rd_address); end
        tick;
        pix_stb = 1'b0; screenend = 1'b0;
        total++; if (o_disp_bank !== 1'b1) begin bad++; $display("FAIL swap_disp_bank: got %b want 1", o_disp_bank); end
        total++; if (o_frame_cnt !== 16'd1) begin bad++; $display("FAIL swap_frame_cnt: got %0d want 1", o_frame_cnt); end
        total++; if (o_frame_start !== 1'b1) begin bad++; $display("FAIL swap_frame_start: got %b want 1", o_frame_start); end
        total++; if (o_drop_cnt !== 8'd0) begin bad++; $display("FAIL swap_drop_cnt: got %0d want 0", o_drop_cnt); end
        total++; if (o_wr_address[AW] !== 1'b0) begin bad++; $display("FAIL swap_wr_msb: got %b want 0", o_wr_address[AW]); end
        total++; if (o_rd_address !== 17'h1ABCD) begin bad++; $display("FAIL swap_rd_addr: got %h want 1abcd", o_rd_address); end
    endtask

    task automatic test_drop;
        pix_stb = 1'b1; tick; pix_stb = 1'b0;
        i_layer_drawing = 1'b1; tick;
        pix_stb = 1'b1; screenend = 1'b1; tick;
        pix_stb = 1'b0; screenend = 1'b0;
        total++; if (o_disp_bank !== 1'b1) begin bad++; $display("FAIL drop_disp_bank: got %b want 1", o_disp_bank); end
        total++; if (o_drop_cnt !== 8'd1) begin bad++; $display("FAIL drop_cnt_1: got %0d want 1", o_drop_cnt); end
        total++; if (o_frame_start !== 1'b0) begin bad++; $display("FAIL drop_frame_start: got %b want 0", o_frame_start); end
        i_draw_we = 1'b1; #1;
        total++; if (o_wr_en !== 1'b1) begin bad++; $display("FAIL drop_still_draw: got %b want 1", o_wr_en); end
        i_draw_we = 1'b0;
        repeat (2) tick;
        i_layer_drawing = 1'b0; pix_stb = 1'b1; screenend = 1'b1; tick;
        pix_stb = 1'b0; screenend = 1'b0;
        total++; if (o_drop_cnt !== 8'd2) begin bad++; $display("FAIL drop_same_cycle: got %0d want 2", o_drop_cnt); end
        total++; if (o_disp_bank !== 1'b1) begin bad++; $display("FAIL drop_same_bank: got %b want 1", o_disp_bank); end
        repeat (2) tick;
        pix_stb = 1'b1; screenend = 1'b1; tick;
        pix_stb = 1'b0; screenend = 1'b0;
        total++; if (o_disp_bank !== 1'b0) begin bad++; $display("FAIL drop_late_swap: got %b want 0", o_disp_bank); end
        total++; if (o_frame_cnt !== 16'd2) begin bad++; $display("FAIL drop_frame_cnt: got %0d want 2", o_frame_cnt); end
        total++; if (o_drop_cnt !== 8'd2) begin bad++; $display("FAIL drop_after_swap: got %0d want 2", o_drop_cnt); end
    endtask

    task automatic test_timeout;
        pix_stb = 1'b1; tick; pix_stb = 1'b0;
        repeat (15) tick;
        total++; if (o_timeout !== 1'b0) begin bad++; $display("FAIL timeout_early: got %b want 0", o_timeout); end
        total++; if (o_frame_start !== 1'b0) begin bad++; $display("FAIL timeout_early_fs: got %b want 0", o_frame_start); end
        tick;
        total++; if (o_timeout !== 1'b1) begin bad++; $display("FAIL timeout_set: got %b want 1", o_timeout); end
        total++; if (o_frame_start !== 1'b1) begin bad++; $display("FAIL timeout_restart: got %b want 1", o_frame_start); end
        pix_stb = 1'b1; tick; pix_stb = 1'b0;
        i_layer_drawing = 1'b1; tick;
        i_layer_drawing = 1'b0; tick;
        pix_stb = 1'b1; screenend = 1'b1; tick;
        pix_stb = 1'b0; screenend = 1'b0;
        total++; if (o_timeout !== 1'b1) begin bad++; $display("FAIL timeout_sticky: got %b want 1", o_timeout); end
        total++; if (o_disp_bank !== 1'b1) begin bad++; $display("FAIL timeout_then_swap: got %b want 1", o_disp_bank); end
        total++; if (o_frame_cnt !== 16'd3) begin bad++; $display("FAIL timeout_frame_cnt: got %0d want 3", o_frame_cnt); end
    endtask

    task automatic test_saturation;
        pix_stb = 1'b1; screenend = 1'b1;
        repeat (10) tick;
        total++; if (o_drop_cnt !== 8'd12) begin bad++; $display("FAIL sat_partial: got %0d want 12", o_drop_cnt); end
        repeat (290) tick;
        pix_stb = 1'b0; screenend = 1'b0;
        total++; if (o_drop_cnt !== 8'd255) begin bad++; $display("FAIL sat_full: got %0d want 255", o_drop_cnt); end
        total++; if (o_disp_bank !== 1'b1) begin bad++; $display("FAIL sat_no_swap: got %b want 1", o_disp_bank); end
        total++; if (o_frame_cnt !== 16'd3) begin bad++; $display("FAIL sat_frame_cnt: got %0d want 3", o_frame_cnt); end
    endtask

    task automatic test_async_reset;
        i_layer_drawing = 1'b0;
        repeat (20) tick;
        total++; if (o_frame_start !== 1'b1) begin bad++; $display("FAIL ar_idle_fs: got %b want 1", o_frame_start); end
        pix_stb = 1'b1; tick; pix_stb = 1'b0;
        i_layer_drawing = 1'b1; tick;
        i_draw_we = 1'b1; #1;
        total++; if (o_wr_en !== 1'b1) begin bad++; $display("FAIL ar_in_draw: got %b want 1", o_wr_en); end
        #1 rst = 1'b0;
        #1;
        total++; if (o_frame_start !== 1'b1) begin bad++; $display("FAIL ar_frame_start: got %b want 1", o_frame_start); end
        total++; if (o_disp_bank !== 1'b0) begin bad++; $display("FAIL ar_disp_bank: got %b want 0", o_disp_bank); end
        total++; if (o_wr_address[AW] !== 1'b1) begin bad++; $display("FAIL ar_wr_msb: got %b want 1", o_wr_address[AW]); end
        total++; if (o_wr_en !== 1'b0) begin bad++; $display("FAIL ar_wr_en: got %b want 0", o_wr_en); end
        total++; if (o_frame_cnt !== 16'd0) begin bad++; $display("FAIL ar_frame_cnt: got %0d want 0", o_frame_cnt); end
        total++; if (o_drop_cnt !== 8'd0) begin bad++; $display("FAIL ar_drop_cnt: got %0d want 0", o_drop_cnt); end
        total++; if (o_timeout !== 1'b0) begin bad++; $display("FAIL ar_timeout: got %b want 0", o_timeout); end
        @(negedge CLK);
        rst = 1'b1; i_layer_drawing = 1'b0; i_draw_we = 1'b0;
        tick;
        total++; if (o_frame_start !== 1'b1) begin bad++; $display("FAIL ar_release_fs: got %b want 1", o_frame_start); end
    endtask

    initial begin
        test_reset;
        test_swap;
        test_drop;
        test_timeout;
        test_saturation;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/frame_buffer_scheduler.md
Name: frame_buffer_scheduler

Overview:
Sequences frame rendering against a double-buffered VRAM, with two banks selected by the address MSB. It starts the layer controller once per frame and gates its VRAM writes into the back (draw) bank. It swaps draw/display banks at the vertical boundary only when drawing has finished, and counts dropped frames. It sits between VGA timing, the layer controller and the dual-port VRAM.

Parameters:
VRAM_A_WIDTH, 16, per-bank VRAM address width (320x180 fits)
WAIT_TIMEOUT, 1024, max CLK cycles allowed between frame-start handshake and layer controller reporting busy
DROP_CNT_WIDTH, 8, width of saturating dropped-frame counter
FRAME_CNT_WIDTH, 16, width of wrapping frame counter

Ports:
CLK  in  1  system clock
rst  in  1  asynchronous, active-low reset
pix_stb  in  1  pixel strobe from VGA timing
screenend  in  1  end-of-active-screen flag from VGA timing
i_layer_drawing  in  1  layer controller busy (its is-layer-drawing output)
i_draw_address  in  VRAM_A_WIDTH  layer controller screen address
i_draw_we  in  1  layer controller write request
i_scan_address  in  VRAM_A_WIDTH  scanout read address
o_frame_start  out  1  drives layer controller screenend input
o_wr_address  out  VRAM_A_WIDTH+1  {draw_bank, i_draw_address}
o_wr_en  out  1  gated VRAM write enable
o_rd_address  out  VRAM_A_WIDTH+1  {disp_bank, i_scan_address}
o_disp_bank  out  1  bank currently scanned out
o_drop_cnt  out  DROP_CNT_WIDTH  frames missed at swap time, saturating
o_frame_cnt  out  FRAME_CNT_WIDTH  completed swaps, wrapping
o_timeout  out  1  sticky: a start handshake timed out

Behaviour:
- vsync = pix_stb & screenend, sampled on CLK.
- Reset values: state S_START, disp_bank 0, draw_bank 1, o_frame_start 1, o_drop_cnt 0, o_frame_cnt 0, o_timeout 0, timeout counter 0.
- Invariant: draw_bank == ~disp_bank at all times.
- States:
  - S_START:
    - o_frame_start = 1.
    - Held until a cycle with pix_stb = 1. That cycle satisfies the layer controller's pix_stb & screenend restart condition.
    - Next state S_WAIT_BUSY; o_frame_start = 0 from the following cycle.
  - S_WAIT_BUSY:
    - Timeout counter increments each cycle.
    - i_layer_drawing = 1 -> S_DRAW, counter cleared.
    - Counter reaches WAIT_TIMEOUT-1 -> S_START, o_timeout set (sticky), counter cleared.
  - S_DRAW:
    - i_layer_drawing = 0 -> S_READY.
  - S_READY:
    - vsync -> swap banks (registered; visible next cycle), o_frame_cnt+1 (wrap), then S_START.
- Dropped frames:
  - vsync in S_START, S_WAIT_BUSY or S_DRAW -> no swap, o_drop_cnt+1, saturating at all-ones.
  - vsync in the same cycle i_layer_drawing falls in S_DRAW counts as a drop; the swap occurs at the next vsync.
- Write gating:
  - o_wr_en = i_draw_we & i_layer_drawing & (state == S_DRAW).
  - Combinational, zero latency.
  - Writes in any other state are discarded.
- Read path:
  - o_rd_address is combinational.
  - Bank bit changes only on the CLK edge following a swap vsync, so scanout never sees a partial frame.
- Swap latency: vsync at cycle n -> o_disp_bank toggled at n+1, o_frame_start = 1 at n+1.
- Reset mid-frame: all state returns to reset values immediately (async). The layer controller is restarted by o_frame_start.

Decomposition:
- Package frame_sched_pkg: state encoding (S_START, S_WAIT_BUSY, S_DRAW, S_READY as 2-bit localparams) and default VRAM_A_WIDTH.
- One sub-module, sat_counter (parameterised width, increment, saturate flag). Used for o_drop_cnt and the timeout counter; o_frame_cnt is a plain wrapping register.

Test Plan:
- Reset release, pix_stb high on 3rd cycle -> o_frame_start 1 for cycles 0-2, 0 from cycle 3; state S_WAIT_BUSY; o_disp_bank = 0; o_wr_address MSB = 1.
- Busy pulse 100 cycles, then vsync -> o_disp_bank 0->1 one cycle after vsync; o_frame_cnt = 1; o_frame_start reasserted; o_drop_cnt = 0.
- vsync while i_layer_drawing = 1 -> o_disp_bank unchanged, o_drop_cnt = 1. Busy drops, next vsync -> swap, o_frame_cnt = 1.
- i_draw_we = 1 with i_layer_drawing = 0 in S_READY -> o_wr_en = 0. In S_DRAW, address 0x1234 -> o_wr_address = {draw_bank, 0x1234}, o_wr_en = 1.
- WAIT_TIMEOUT = 16, i_layer_drawing held 0 -> after 16 cycles in S_WAIT_BUSY, o_timeout = 1 and o_frame_start reasserts.
- Force 300 missed vsyncs with DROP_CNT_WIDTH = 8 -> o_drop_cnt = 255. Assert rst low mid-S_DRAW -> all outputs return to reset values without a clock edge.
